instr_fetch: RTL and testbench

Instruction fetch unit feeding the CPU control FSM. It owns the program counter and answers the FSM's `PCEn` fetch request. It reads one 16-bit instruction word from a synchronous instruction RAM with 1-cycle read latency and presents the word on `Instr` with a one-cycle `InstrValid` strobe. It also accepts branch/jump redirects from the datapath.

---
 rtl/instr_fetch_if.sv | 24 ++
 rtl/instr_fetch.sv | 63 ++++++
 tb/tb_instr_fetch.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Fetch unit bus: control-FSM request, datapath redirect, instruction RAM port and fetched-word outputs.
// The fetch unit uses the slave view; whoever drives it uses the master view.
interface instr_fetch_if;
    logic        PCEn;
    logic        Branch;
    logic [15:0] BranchTarget;
    logic [15:0] MemData;
    logic [15:0] MemAddr;
    logic        MemRdEn;
    logic [15:0] Instr;
    logic        InstrValid;
    logic [15:0] PC;
    logic        Busy;

    modport slave (
        input  PCEn, Branch, BranchTarget, MemData,
        output MemAddr, MemRdEn, Instr, InstrValid, PC, Busy
    );

    modport master (
        output PCEn, Branch, BranchTarget, MemData,
        input  MemAddr, MemRdEn, Instr, InstrValid, PC, Busy
    );
endinterface

// File: rtl/instr_fetch.sv
// Program counter plus single-outstanding fetch from a 1-cycle synchronous instruction RAM.
// PCEn to InstrValid is 2 cycles; PCEn is dropped (not queued) while Busy, so at most one fetch per 2 cycles.
module instr_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic          Clk,
    input  logic          Reset,
    instr_fetch_if.slave  bus
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t      state;
    logic [15:0] pc;
    logic [15:0] fetch_addr;
    logic [15:0] instr;
    logic        instr_valid;
    logic [15:0] issue_addr;

    // A redirect arriving together with a request steers the fetch itself.
    assign issue_addr = bus.Branch ? bus.BranchTarget : pc;

    assign bus.MemRdEn    = (state == S_IDLE) && bus.PCEn && !Reset;
    assign bus.MemAddr    = (state == S_WAIT) ? fetch_addr : issue_addr;
    assign bus.Busy       = (state == S_WAIT);
    assign bus.Instr      = instr;
    assign bus.InstrValid = instr_valid;
    assign bus.PC         = pc;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            fetch_addr  <= RESET_PC;
            instr       <= 16'h0000;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    instr_valid <= 1'b0;
                    if (bus.PCEn) begin
                        fetch_addr <= issue_addr;
                        state      <= S_WAIT;
                    end else if (bus.Branch) begin
                        pc <= bus.BranchTarget;
                    end
                end
                S_WAIT: begin
                    // In-flight word is always delivered; a redirect only replaces the increment.
                    instr       <= bus.MemData;
                    instr_valid <= 1'b1;
                    pc          <= bus.Branch ? bus.BranchTarget : fetch_addr + 16'd1;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus a randomized run against a transaction model.
module tb_instr_fetch;

    localparam logic [15:0] RST_PC = 16'h0000;

    logic Clk = 1'b0;
    logic Reset;
    int   n_checks = 0;
    int   n_pass   = 0;

    logic [15:0] ram [0:65535];

    instr_fetch_if bus ();

    instr_fetch #(.RESET_PC(RST_PC)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    // Synchronous instruction RAM, one cycle read latency.
    always @(posedge Clk) begin
        if (bus.MemRdEn) bus.MemData <= ram[bus.MemAddr];
    end

    task automatic tick;
        @(negedge Clk);
    endtask

    task automatic do_reset;
        tick;
        Reset = 1'b1; bus.PCEn = 1'b0; bus.Branch = 1'b0;
        tick;
        Reset = 1'b0;
    endtask

    task automatic test_reset;
        Reset = 1'b1; bus.PCEn = 1'b1; bus.Branch = 1'b1; bus.BranchTarget = 16'h1234;
        tick; tick; #1;
        n_checks++; if (bus.PC !== RST_PC) $display("FAIL reset_pc got %h want %h", bus.PC, RST_PC); else n_pass++;
        n_checks++; if (bus.Instr !== 16'h0000) $display("FAIL reset_instr got %h want 0000", bus.Instr); else n_pass++;
        n_checks++; if (bus.InstrValid !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.InstrValid); else n_pass++;
        n_checks++; if (bus.Busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.Busy); else n_pass++;
        n_checks++; if (bus.MemRdEn !== 1'b0) $display("FAIL reset_rden got %b want 0", bus.MemRdEn); else n_pass++;
        tick;
        Reset = 1'b0; bus.PCEn = 1'b0; bus.Branch = 1'b0;
        #1;
        n_checks++; if (bus.MemAddr !== RST_PC) $display("FAIL reset_memaddr got %h want %h", bus.MemAddr, RST_PC); else n_pass++;
    endtask

    task automatic test_single;
        ram[0] = 16'h5103;
        tick; bus.PCEn = 1'b1; #1;
        n_checks++; if (bus.MemRdEn !== 1'b1) $display("FAIL single_rden got %b want 1", bus.MemRdEn); else n_pass++;
        n_checks++; if (bus.MemAddr !== 16'h0000) $display("FAIL single_addr got %h want 0000", bus.MemAddr); else n_pass++;
        tick; bus.PCEn = 1'b0; #1;
        n_checks++; if (bus.Busy !== 1'b1) $display("FAIL single_busy got %b want 1", bus.Busy); else n_pass++;
        tick; #1;
        n_checks++; if (bus.Instr !== 16'h5103) $display("FAIL single_instr got %h want 5103", bus.Instr); else n_pass++;
        n_checks++; if (bus.InstrValid !== 1'b1) $display("FAIL single_valid got %b want 1", bus.InstrValid); else n_pass++;
        n_checks++; if (bus.PC !== 16'h0001) $display("FAIL single_pc got %h want 0001", bus.PC); else n_pass++;
        tick; #1;
        n_checks++; if (bus.InstrValid !== 1'b0) $display("FAIL single_pulse got %b want 0", bus.InstrValid); else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [15:0] vals [0:2];
        logic        exp_rd;
        logic        exp_vld;
        vals[0] = 16'h1111; vals[1] = 16'h2222; vals[2] = 16'h3333;
        for (int k = 0; k < 3; k++) ram[k] = vals[k];
        do_reset;
        for (int i = 0; i < 8; i++) begin
            tick; bus.PCEn = (i < 6); #1;
            exp_rd  = (i % 2 == 0) && (i < 6);
            exp_vld = (i == 2) || (i == 4) || (i == 6);
            n_checks++; if (bus.MemRdEn !== exp_rd) $display("FAIL b2b_rden cyc %0d got %b want %b", i, bus.MemRdEn, exp_rd); else n_pass++;
            if (exp_rd) begin
                n_checks++; if (bus.MemAddr !== 16'(i / 2)) $display("FAIL b2b_addr cyc %0d got %h want %h", i, bus.MemAddr, 16'(i / 2)); else n_pass++;
            end
            n_checks++; if (bus.InstrValid !== exp_vld) $display("FAIL b2b_valid cyc %0d got %b want %b", i, bus.InstrValid, exp_vld); else n_pass++;
            if (exp_vld) begin
                n_checks++; if (bus.Instr !== vals[i / 2 - 1]) $display("FAIL b2b_instr cyc %0d got %h want %h", i, bus.Instr, vals[i / 2 - 1]); else n_pass++;
            end
        end
        n_checks++; if (bus.PC !== 16'h0003) $display("FAIL b2b_pc got %h want 0003", bus.PC); else n_pass++;
    endtask

    task automatic test_branch_issue;
        ram[16'h0040] = 16'hABCD;
        tick; bus.Branch = 1'b1; bus.BranchTarget = 16'h0005;
        tick; bus.Branch = 1'b0; #1;
        n_checks++; if (bus.PC !== 16'h0005) $display("FAIL brissue_load got %h want 0005", bus.PC); else n_pass++;
        tick; bus.PCEn = 1'b1; bus.Branch = 1'b1; bus.BranchTarget = 16'h0040; #1;
        n_checks++; if (bus.MemAddr !== 16'h0040) $display("FAIL brissue_addr got %h want 0040", bus.MemAddr); else n_pass++;
        tick; bus.PCEn = 1'b0; bus.Branch = 1'b0;
        tick; #1;
        n_checks++; if (bus.Instr !== 16'hABCD) $display("FAIL brissue_instr got %h want abcd", bus.Instr); else n_pass++;
        n_checks++; if (bus.PC !== 16'h0041) $display("FAIL brissue_pc got %h want 0041", bus.PC); else n_pass++;
    endtask

    task automatic test_branch_wait;
        ram[7] = 16'h7A7A;
        tick; bus.Branch = 1'b1; bus.BranchTarget = 16'h0007;
        tick; bus.Branch = 1'b0; bus.PCEn = 1'b1; #1;
        n_checks++; if (bus.MemAddr !== 16'h0007) $display("FAIL brwait_addr got %h want 0007", bus.MemAddr); else n_pass++;
        tick; bus.PCEn = 1'b0; bus.Branch = 1'b1; bus.BranchTarget = 16'h0100;
        tick; bus.Branch = 1'b0; #1;
        n_checks++; if (bus.Instr !== 16'h7A7A) $display("FAIL brwait_instr got %h want 7a7a", bus.Instr); else n_pass++;
        n_checks++; if (bus.InstrValid !== 1'b1) $display("FAIL brwait_valid got %b want 1", bus.InstrValid); else n_pass++;
        n_checks++; if (bus.PC !== 16'h0100) $display("FAIL brwait_pc got %h want 0100", bus.PC); else n_pass++;
    endtask

    task automatic test_wrap;
        ram[16'hFFFF] = 16'hBEEF;
        tick; bus.Branch = 1'b1; bus.BranchTarget = 16'hFFFF;
        tick; bus.Branch = 1'b0; bus.PCEn = 1'b1; #1;
        n_checks++; if (bus.MemAddr !== 16'hFFFF) $display("FAIL wrap_addr got %h want ffff", bus.MemAddr); else n_pass++;
        tick; bus.PCEn = 1'b0;
        tick; #1;
        n_checks++; if (bus.PC !== 16'h0000) $display("FAIL wrap_pc got %h want 0000", bus.PC); else n_pass++;
        n_checks++; if (bus.Instr !== 16'hBEEF) $display("FAIL wrap_instr got %h want beef", bus.Instr); else n_pass++;
    endtask

    task automatic test_reset_wait;
        tick; bus.PCEn = 1'b1;
        tick; bus.PCEn = 1'b0; Reset = 1'b1; #1;
        n_checks++; if (bus.Busy !== 1'b1) $display("FAIL rstwait_busy_pre got %b want 1", bus.Busy); else n_pass++;
        tick; Reset = 1'b0; #1;
        n_checks++; if (bus.InstrValid !== 1'b0) $display("FAIL rstwait_valid got %b want 0", bus.InstrValid); else n_pass++;
        n_checks++; if (bus.Instr !== 16'h0000) $display("FAIL rstwait_instr got %h want 0000", bus.Instr); else n_pass++;
        n_checks++; if (bus.PC !== RST_PC) $display("FAIL rstwait_pc got %h want %h", bus.PC, RST_PC); else n_pass++;
        n_checks++; if (bus.Busy !== 1'b0) $display("FAIL rstwait_busy got %b want 0", bus.Busy); else n_pass++;
        n_checks++; if (bus.MemRdEn !== 1'b0) $display("FAIL rstwait_rden got %b want 0", bus.MemRdEn); else n_pass++;
        tick; #1;
        n_checks++; if (bus.InstrValid !== 1'b0) $display("FAIL rstwait_late_valid got %b want 0", bus.InstrValid); else n_pass++;
    endtask

    // Transaction model: a request is either in flight or not; delivery happens one cycle after issue.
    task automatic test_random;
        logic [15:0] m_pc, m_instr, m_addr;
        logic        m_inflight, m_valid, exp_rd;
        logic [15:0] exp_maddr;
        do_reset;
        m_pc = RST_PC; m_instr = 16'h0000; m_valid = 1'b0; m_inflight = 1'b0; m_addr = RST_PC;
        for (int c = 0; c < 600; c++) begin
            tick;
            bus.PCEn         = ($urandom_range(0, 1) == 1);
            bus.Branch       = ($urandom_range(0, 3) == 0);
            bus.BranchTarget = 16'($urandom);
            #1;
            exp_rd    = !m_inflight && bus.PCEn;
            exp_maddr = m_inflight ? m_addr : (bus.Branch ? bus.BranchTarget : m_pc);
            n_checks++; if (bus.Busy !== m_inflight) $display("FAIL rnd_busy cyc %0d got %b want %b", c, bus.Busy, m_inflight); else n_pass++;
            n_checks++; if (bus.MemRdEn !== exp_rd) $display("FAIL rnd_rden cyc %0d got %b want %b", c, bus.MemRdEn, exp_rd); else n_pass++;
            n_checks++; if (bus.MemAddr !== exp_maddr) $display("FAIL rnd_addr cyc %0d got %h want %h", c, bus.MemAddr, exp_maddr); else n_pass++;
            n_checks++; if (bus.PC !== m_pc) $display("FAIL rnd_pc cyc %0d got %h want %h", c, bus.PC, m_pc); else n_pass++;
            n_checks++; if (bus.InstrValid !== m_valid) $display("FAIL rnd_valid cyc %0d got %b want %b", c, bus.InstrValid, m_valid); else n_pass++;
            n_checks++; if (bus.Instr !== m_instr) $display("FAIL rnd_instr cyc %0d got %h want %h", c, bus.Instr, m_instr); else n_pass++;
            if (m_inflight) begin
                m_instr    = ram[m_addr];
                m_valid    = 1'b1;
                m_pc       = bus.Branch ? bus.BranchTarget : m_addr + 16'd1;
                m_inflight = 1'b0;
            end else begin
                m_valid = 1'b0;
                if (bus.PCEn) begin
                    m_addr     = exp_maddr;
                    m_inflight = 1'b1;
                end else if (bus.Branch) begin
                    m_pc = bus.BranchTarget;
                end
            end
        end
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) ram[a] = 16'($urandom);
        bus.MemData = 16'h0000;
        bus.PCEn = 1'b0; bus.Branch = 1'b0; bus.BranchTarget = 16'h0000;
        Reset = 1'b1;
        test_reset;
        test_single;
        test_back_to_back;
        test_branch_issue;
        test_branch_wait;
        test_wrap;
        test_reset_wait;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
